dds_lut_loader: RTL and testbench
=================================

Name: dds_lut_loader

Overview:
- Writer side of the DDS configuration interface: produces the `cfg`/`cfg_ce` byte stream that fills the 4096x8 DDS waveform LUT.
- Drives the DDS `step` port so the DDS LUT write pointer is rewound before a load and the DDS is held idle while the load runs.
- Waveform source is either on-chip generation (ramp, triangle, square with programmable duty) or a host byte stream over valid/ready.
- Sits between the control register block and the DDS instance.

Parameters:
- ADDR_W, 12, LUT address width; LUT depth is 2**ADDR_W and must match the DDS LUT.
- DATA_W, 8, LUT sample width, signed two's complement.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle load request; ignored while busy
- abort  in  1  cancels the load in progress
- mode  in  2  0=ramp, 1=triangle, 2=square, 3=host stream; latched on accepted start
- duty  in  ADDR_W  square high-phase length in samples; latched on accepted start
- ampl  in  8  amplitude scale, unsigned Q0.8; used only with DDS_LUT_LOADER_AMPL_EN
- s_data  in  DATA_W  host sample
- s_valid  in  1  host sample valid
- s_ready  out  1  loader accepts host sample
- step_in  in  32  user tuning word
- step_out  out  32  tuning word to the DDS
- cfg  out  DATA_W  LUT byte to the DDS
- cfg_ce  out  1  LUT byte write strobe
- busy  out  1  load in progress
- done  out  1  one-cycle pulse when a load completes

Behaviour:
- All outputs are registered.
- Reset values: cfg=0, cfg_ce=0, s_ready=0, busy=0, done=0, step_out=0. Index counter=0. State=IDLE.
- FSM states: IDLE, SYNC, LOAD, DONE.
- IDLE:
  - step_out follows step_in with 1-cycle latency.
  - start=1 latches mode and duty, then goes to SYNC.
- SYNC, exactly 1 cycle:
  - step_out=1 and cfg_ce=0. The DDS sees a nonzero step, which rewinds its LUT pointer to 0.
  - busy=1.
  - Next state is LOAD with index=0.
- LOAD:
  - step_out=0 and busy=1.
  - Generated modes (0-2): cfg_ce=1 on 4096 consecutive cycles, with cfg=sample(index).
  - Stream mode (3):
    - s_ready=1 in every LOAD cycle.
    - A transfer occurs when s_valid&&s_ready. Each transfer gives cfg=s_data and cfg_ce=1 on the next cycle, and index++.
    - A cycle with s_valid=0 gives cfg_ce=0 and the index holds.
  - The cycle after the cfg_ce carrying index 4095, the state is DONE. The index wraps to 0 and s_ready drops.
- DONE, 1 cycle:
  - done=1, busy=0, step_out=0.
  - Returns to IDLE, where step_out=step_in resumes on the following cycle.
- Sample generation (signed 8-bit, index i, 12 bits):
  - Ramp: {~i[11], i[10:4]}. Covers -128..127 monotonically.
  - Triangle: t = i[11] ? ~i[10:3] : i[10:3]; sample = {~t[7], t[6:0]}.
  - Square: i < duty_latched ? 8'sd127 : -8'sd128. duty=0 gives all -128.
- start while busy or in DONE is ignored.
- abort at any state other than IDLE:
  - Next cycle: IDLE, cfg_ce=0, s_ready=0, busy=0, no done pulse, step_out=0.
  - step_out=step_in resumes the following cycle.
  - A partially written DDS LUT is left as is. The next load rewinds it via SYNC.
- Simultaneous start and abort in IDLE: start wins.
- Reset mid-load: every output returns to its reset value on the next cycle, with no done pulse.

Optional Feature:
- Macro: DDS_LUT_LOADER_AMPL_EN.
- Defined:
  - In generated modes, cfg = (sample * $signed({1'b0,ampl})) >>> 8, arithmetic shift, truncated to 8 bits.
  - ampl is latched on an accepted start.
  - Adds one pipeline register, so the first cfg_ce follows SYNC by 2 cycles instead of 1. During that extra cycle cfg_ce=0 and step_out=0.
  - Stream mode is unscaled.
- Undefined: ampl is unused and latency is as specified above.

Decomposition:
- Shared package dds_pkg holds:
  - DDS_ADDR_W=12, DDS_DATA_W=8, DDS_LUT_DEPTH=4096.
  - Typedef dds_sample_t (logic signed [7:0]).
  - Enum dds_wave_mode_e {WAVE_RAMP, WAVE_TRI, WAVE_SQUARE, WAVE_STREAM}.
  - Enum loader_state_e.
- One sub-module: dds_wave_gen. It is combinational, computing (mode, index, duty) -> sample, and is reused by the bench's scoreboard model.

Test Plan:
- Ramp, step_in=32'h0100_0000, start:
  - step_out=1 for 1 cycle, then 0.
  - 4096 consecutive cfg_ce with cfg[0]=-128, cfg[16]=-127, cfg[4095]=127.
  - done 1 cycle later; step_out returns to 32'h0100_0000.
- Square, duty=12'd1024: samples 0..1023=127 and 1024..4095=-128. Repeat with duty=0: all 4096 samples are -128.
- Triangle: cfg[0]=-128, cfg[2047]=127, cfg[2048]=127, cfg[4095]=-128. Sequence is symmetric.
- Stream with s_valid toggling at a random 50% rate:
  - Exactly 4096 cfg_ce pulses, in order, with cfg equal to the sent bytes.
  - No cfg_ce during s_valid=0 gaps; done after the 4096th byte.
- abort after 100 cfg_ce:
  - cfg_ce=0 next cycle, no done, busy=0.
  - A new start performs SYNC and a full 4096-byte load.
  - Connected to a DDS model, the LUT matches the second load.
- Reset asserted mid-LOAD: all outputs 0 next cycle. A start during busy is ignored (done count=1). With DDS_LUT_LOADER_AMPL_EN and ampl=8'h80, the ramp gives cfg[0]=-64.

Source files
------------

// File: rtl/dds_pkg.sv
// Shared DDS definitions: LUT geometry, sample type, waveform modes,
// loader FSM states and the amplitude-scaling helper.
package dds_pkg;

  localparam int DDS_ADDR_W    = 12;
  localparam int DDS_DATA_W    = 8;
  localparam int DDS_LUT_DEPTH = 4096;

  typedef logic signed [7:0] dds_sample_t;

  typedef enum logic [1:0] {
    WAVE_RAMP   = 2'd0,
    WAVE_TRI    = 2'd1,
    WAVE_SQUARE = 2'd2,
    WAVE_STREAM = 2'd3
  } dds_wave_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_LOAD = 2'd2,
    ST_DONE = 2'd3
  } loader_state_e;

  // (sample * unsigned Q0.8 gain) >>> 8, truncated back to a sample.
  function automatic dds_sample_t dds_scale(input dds_sample_t s, input logic [7:0] a);
    logic signed [16:0] p;
    p = 17'(s) * 17'($signed({1'b0, a}));
    p = p >>> 8;
    return p[7:0];
  endfunction

endpackage

// File: rtl/dds_wave_gen.sv
// Combinational waveform generator: (mode, index, duty) -> signed sample.
// Ports:
//   mode   - waveform select (dds_wave_mode_e encoding); stream mode yields 0
//   index  - LUT position being generated
//   duty   - square-wave high-phase length in samples
//   sample - signed two's-complement LUT byte
module dds_wave_gen
  import dds_pkg::*;
#(
  parameter int ADDR_W = DDS_ADDR_W
) (
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] index,
  input  logic [ADDR_W-1:0] duty,
  output logic [7:0]        sample
);

  logic [7:0] tri_t;

  // NOTE: every output of an always_comb gets a value on every path,
  // otherwise synthesis infers a latch.
  always_comb begin
    // Second half of the table walks the same ramp backwards.
    tri_t  = index[ADDR_W-1] ? ~index[ADDR_W-2:ADDR_W-9] : index[ADDR_W-2:ADDR_W-9];
    sample = '0;
    case (dds_wave_mode_e'(mode))
      WAVE_RAMP:   sample = {~index[ADDR_W-1], index[ADDR_W-2:ADDR_W-8]};
      WAVE_TRI:    sample = {~tri_t[7], tri_t[6:0]};
      WAVE_SQUARE: sample = (index < duty) ? 8'h7f : 8'h80;
      default:     sample = '0;
    endcase
  end

endmodule

// File: rtl/dds_lut_loader.sv
// Writer side of the DDS configuration port: rewinds the DDS LUT pointer
// with a one-cycle nonzero step, then streams 2**ADDR_W bytes on cfg/cfg_ce
// from the on-chip generator or from the host valid/ready stream.
// Optional feature macro: DDS_LUT_LOADER_AMPL_EN (amplitude scaling of
// generated waveforms, one extra pipeline stage).
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   start, abort      - load request (IDLE only) / cancel load in progress
//   mode, duty, ampl  - waveform select, square duty, gain (latched on start)
//   s_data/s_valid/s_ready - host sample stream (mode 3)
//   step_in/step_out  - user tuning word in, tuning word to the DDS
//   cfg, cfg_ce       - LUT byte and write strobe to the DDS
//   busy, done        - load in progress, one-cycle completion pulse
module dds_lut_loader
  import dds_pkg::*;
#(
  parameter int ADDR_W = DDS_ADDR_W,
  parameter int DATA_W = DDS_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] duty,
  input  logic [7:0]        ampl,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [31:0]       step_in,
  output logic [31:0]       step_out,
  output logic [DATA_W-1:0] cfg,
  output logic              cfg_ce,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  loader_state_e     state;
  dds_wave_mode_e    mode_q;
  logic [ADDR_W-1:0] idx;        // index of the next byte to issue
  logic [ADDR_W-1:0] duty_q;
  logic              issue_done; // generated modes: all bytes issued
  logic              out_last;   // byte currently on cfg is the final one

  logic [7:0]        gen_sample;
  logic              issue;
  logic              issue_last;
  logic [DATA_W-1:0] issue_data;
  logic              emit_ce;
  logic              emit_last;
  logic [DATA_W-1:0] emit_data;
  logic              flush;

  dds_wave_gen #(.ADDR_W(ADDR_W)) u_wave_gen (
    .mode   (mode_q),
    .index  (idx),
    .duty   (duty_q),
    .sample (gen_sample)
  );

  // A byte is issued in SYNC already so that, without the extra gain stage,
  // the first cfg_ce lands in the first LOAD cycle.
  always_comb begin
    if (mode_q == WAVE_STREAM) begin
      issue      = (state == ST_LOAD) && s_ready && s_valid;
      issue_data = s_data;
    end else begin
      issue      = (state == ST_SYNC) || ((state == ST_LOAD) && !issue_done);
      issue_data = gen_sample;
    end
    issue_last = issue && (idx == LAST_IDX);
  end

  assign flush = abort && (state != ST_IDLE);

`ifdef DDS_LUT_LOADER_AMPL_EN
  logic [7:0]        ampl_q;
  logic              pipe_ce;
  logic              pipe_last;
  logic [DATA_W-1:0] pipe_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      ampl_q    <= '0;
      pipe_ce   <= 1'b0;
      pipe_last <= 1'b0;
      pipe_data <= '0;
    end else begin
      if (state == ST_IDLE && start) ampl_q <= ampl;
      pipe_ce   <= issue && !flush;
      pipe_last <= issue_last && !flush;
      pipe_data <= issue_data;
    end
  end

  // Host samples are written verbatim; only generated waveforms are scaled.
  assign emit_ce   = pipe_ce;
  assign emit_last = pipe_last;
  assign emit_data = (mode_q == WAVE_STREAM) ? pipe_data : dds_scale(pipe_data, ampl_q);
`else
  logic ampl_unused;
  assign ampl_unused = ^ampl;

  assign emit_ce   = issue;
  assign emit_last = issue_last;
  assign emit_data = issue_data;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      mode_q     <= WAVE_RAMP;
      duty_q     <= '0;
      idx        <= '0;
      issue_done <= 1'b0;
      out_last   <= 1'b0;
      cfg        <= '0;
      cfg_ce     <= 1'b0;
      s_ready    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      step_out   <= '0;
    end else begin
      cfg_ce   <= 1'b0;
      out_last <= 1'b0;
      done     <= 1'b0;
      step_out <= '0;
      if (flush) begin
        state      <= ST_IDLE;
        idx        <= '0;
        issue_done <= 1'b0;
        s_ready    <= 1'b0;
        busy       <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            step_out <= step_in;
            if (start) begin
              mode_q     <= dds_wave_mode_e'(mode);
              duty_q     <= duty;
              idx        <= '0;
              issue_done <= 1'b0;
              step_out   <= 32'd1;  // nonzero step rewinds the DDS LUT pointer
              busy       <= 1'b1;
              state      <= ST_SYNC;
            end
          end
          ST_SYNC: begin
            s_ready <= (mode_q == WAVE_STREAM);
            state   <= ST_LOAD;
          end
          ST_LOAD: begin
            if (out_last) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= ST_DONE;
            end
          end
          default: state <= ST_IDLE;
        endcase

        if (issue) begin
          idx <= idx + ADDR_W'(1);
          // s_ready falls with the last accepted byte so no extra byte is
          // taken while the final write drains out.
          if (issue_last) begin
            issue_done <= 1'b1;
            s_ready    <= 1'b0;
          end
        end

        if (emit_ce) begin
          cfg      <= emit_data;
          cfg_ce   <= 1'b1;
          out_last <= emit_last;
        end
      end
    end
  end

endmodule

// File: tb/tb_dds_lut_loader.sv
module tb_dds_lut_loader;

  localparam int DEPTH = 4096;
`ifdef DDS_LUT_LOADER_AMPL_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        reset, start, abort, s_valid, s_ready, cfg_ce, busy, done;
  logic [1:0]  mode;
  logic [11:0] duty;
  logic [7:0]  ampl, s_data, cfg;
  logic [31:0] step_in, step_out;

  int total = 0;
  int bad   = 0;

  logic [7:0]  exp_q[$];
  logic [7:0]  last_exp [DEPTH];
  logic [7:0]  dds_lut  [DEPTH];
  logic [11:0] dds_ptr = '0;
  int          done_cnt = 0;
  bit          strm_en = 1'b0;
  int          strm_sent = 0;

  always #5 clk = ~clk;

  dds_lut_loader dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .mode(mode),
    .duty(duty), .ampl(ampl), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .step_in(step_in), .step_out(step_out), .cfg(cfg),
    .cfg_ce(cfg_ce), .busy(busy), .done(done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference waveform from the plain arithmetic definition of each shape.
  function automatic int ref_sample(input int m, input int i, input int d);
    case (m)
      0:       return i / 16 - 128;
      1:       return (i < 2048) ? (i / 8 - 128) : ((4095 - i) / 8 - 128);
      2:       return (i < d) ? 127 : -128;
      default: return 0;
    endcase
  endfunction

  function automatic logic [7:0] ref_out(input int m, input int i, input int d, input int a);
    int s;
    s = ref_sample(m, i, d);
`ifdef DDS_LUT_LOADER_AMPL_EN
    s = (s * a) >>> 8;
`endif
    return s[7:0];
  endfunction

  // Scoreboard monitor plus a DDS LUT model fed by the loader outputs.
  initial begin
    forever begin
      @(negedge clk);
      if (cfg_ce) begin
        if (exp_q.size() == 0) check("unexpected_cfg_ce", 32'(cfg_ce), 32'd0);
        else check("cfg_byte", 32'(cfg), 32'(exp_q.pop_front()));
      end
      if (done) done_cnt++;
      if (step_out != 0) dds_ptr = '0;
      else if (cfg_ce) begin
        dds_lut[dds_ptr] = cfg;
        dds_ptr = dds_ptr + 12'd1;
      end
    end
  end

  // Host stream driver: random 50% valid; expectations queued on handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (strm_en && strm_sent < DEPTH) begin
        s_valid = 1'($urandom_range(0, 1));
        s_data  = 8'($urandom);
        if (s_valid && s_ready) begin
          exp_q.push_back(s_data);
          last_exp[strm_sent] = s_data;
          strm_sent++;
        end
      end else begin
        s_valid = 1'b0;
      end
    end
  end

  task automatic pulse_start(input int m, input int d, input int a, input bit with_abort);
    @(negedge clk);
    mode  = 2'(m);
    duty  = 12'(d);
    ampl  = 8'(a);
    start = 1'b1;
    abort = with_abort;
    @(negedge clk);  // SYNC cycle
    start = 1'b0;
    abort = 1'b0;
    check("sync_step_out", step_out, 32'd1);
    check("sync_busy", 32'(busy), 32'd1);
    check("sync_cfg_ce", 32'(cfg_ce), 32'd0);
  endtask

  task automatic run_load(input int m, input int d, input int a, input bit with_abort, input bit poke);
    int cyc = 0, ce_seen = 0, first = -1, base_done, lut_bad = 0;
    bit finished = 1'b0;
    exp_q.delete();
    if (m != 3) begin
      for (int i = 0; i < DEPTH; i++) begin
        last_exp[i] = ref_out(m, i, d, a);
        exp_q.push_back(last_exp[i]);
      end
    end else begin
      strm_sent = 0;
      strm_en   = 1'b1;
    end
    base_done = done_cnt;
    pulse_start(m, d, a, with_abort);
    while (cyc < 20000) begin
      @(negedge clk);
      cyc++;
      start = poke && (ce_seen == 500);
      mode  = 2'd2;
      if (cyc == 1) begin
        check("load_step_out", step_out, 32'd0);
        check("load_busy", 32'(busy), 32'd1);
      end
      if (m != 3 && cyc < LAT) check("pre_ce_gap", 32'(cfg_ce), 32'd0);
      if (m != 3 && cyc == LAT) check("first_ce_latency", 32'(cfg_ce), 32'd1);
      if (cfg_ce) begin
        if (first < 0) first = cyc;
        ce_seen++;
      end
      if (done) begin
        finished = 1'b1;
        break;
      end
    end
    start = 1'b0;
    strm_en = 1'b0;
    check("done_seen", 32'(finished), 32'd1);
    check("done_busy", 32'(busy), 32'd0);
    check("done_step_out", step_out, 32'd0);
    check("done_s_ready", 32'(s_ready), 32'd0);
    check("ce_count", 32'(ce_seen), 32'(DEPTH));
    if (m != 3) check("ce_contiguous", 32'(cyc - first), 32'(DEPTH));
    @(negedge clk);
    check("done_single_pulse", 32'(done), 32'd0);
    @(negedge clk);
    check("idle_step_resume", step_out, step_in);
    check("done_count", 32'(done_cnt - base_done), 32'd1);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < DEPTH; i++) if (dds_lut[i] !== last_exp[i]) lut_bad++;
    check("dds_lut_match", 32'(lut_bad), 32'd0);
  endtask

  // Cancel (abort) or reset after n bytes; checks the interrupted state.
  task automatic run_cut(input int m, input int n, input bit use_reset);
    int cyc = 0, ce_seen = 0, base_done;
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(ref_out(m, i, 0, 200));
    base_done = done_cnt;
    pulse_start(m, 0, 200, 1'b0);
    while (cyc < 1000 && ce_seen < n) begin
      @(negedge clk);
      cyc++;
      if (cfg_ce) ce_seen++;
    end
    check("cut_ce_count", 32'(ce_seen), 32'(n));
    if (use_reset) reset = 1'b1;
    else abort = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    abort = 1'b0;
    exp_q.delete();
    check("cut_cfg_ce", 32'(cfg_ce), 32'd0);
    check("cut_busy", 32'(busy), 32'd0);
    check("cut_done", 32'(done), 32'd0);
    check("cut_s_ready", 32'(s_ready), 32'd0);
    check("cut_step_out", step_out, 32'd0);
    if (use_reset) check("reset_cfg", 32'(cfg), 32'd0);
    ce_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (cfg_ce) ce_seen++;
    end
    check("cut_no_more_ce", 32'(ce_seen), 32'd0);
    check("cut_no_done", 32'(done_cnt - base_done), 32'd0);
    check("cut_step_resume", step_out, step_in);
  endtask

  initial begin
    int mism;
    reset = 1'b1; start = 1'b0; abort = 1'b0; mode = '0; duty = '0;
    ampl = '0; s_data = '0; s_valid = 1'b0; step_in = 32'h0100_0000;
    repeat (3) @(negedge clk);
    check("rst_cfg", 32'(cfg), 32'd0);
    check("rst_cfg_ce", 32'(cfg_ce), 32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_step_out", step_out, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("idle_step_follow", step_out, step_in);

    // Ramp, with a start pulse mid-load that must be ignored.
    run_load(0, 0, $urandom_range(0, 255), 1'b0, 1'b1);
`ifndef DDS_LUT_LOADER_AMPL_EN
    check("ramp_lut0", 32'(dds_lut[0]), 32'h80);
    check("ramp_lut16", 32'(dds_lut[16]), 32'h81);
    check("ramp_lut4095", 32'(dds_lut[4095]), 32'h7f);
`endif

    run_load(2, 1024, $urandom_range(0, 255), 1'b0, 1'b0);
`ifndef DDS_LUT_LOADER_AMPL_EN
    check("sq1024_lut1023", 32'(dds_lut[1023]), 32'h7f);
    check("sq1024_lut1024", 32'(dds_lut[1024]), 32'h80);
`endif
    run_load(2, 0, $urandom_range(0, 255), 1'b0, 1'b0);
    mism = 0;
    for (int i = 0; i < DEPTH; i++) if (dds_lut[i] !== dds_lut[0]) mism++;
    check("sq0_flat", 32'(mism), 32'd0);

    // Triangle, start issued together with abort in IDLE (start wins).
    run_load(1, 0, $urandom_range(0, 255), 1'b1, 1'b0);
    mism = 0;
    for (int i = 0; i < DEPTH; i++) if (dds_lut[i] !== dds_lut[DEPTH-1-i]) mism++;
    check("tri_symmetric", 32'(mism), 32'd0);
`ifndef DDS_LUT_LOADER_AMPL_EN
    check("tri_lut0", 32'(dds_lut[0]), 32'h80);
    check("tri_lut2047", 32'(dds_lut[2047]), 32'h7f);
    check("tri_lut2048", 32'(dds_lut[2048]), 32'h7f);
    check("tri_lut4095", 32'(dds_lut[4095]), 32'h80);
`endif

    run_load(3, 0, 0, 1'b0, 1'b0);

    step_in = 32'h0000_1234;
    run_cut(1, 100, 1'b0);
    run_load(2, $urandom_range(1, 4095), $urandom_range(0, 255), 1'b0, 1'b0);

    run_cut(0, 50, 1'b1);

`ifdef DDS_LUT_LOADER_AMPL_EN
    run_load(0, 0, 8'h80, 1'b0, 1'b0);
    check("ampl_ramp_lut0", 32'(dds_lut[0]), 32'hc0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
